// File: rtl/hex_scan_counter.sv
// hex_scan_counter: N-digit up/down hex counter with load, wrap-around and a
// time-multiplexed active-low 7-segment scan driver with leading-zero blanking.
module hex_scan_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                    CLK100MHZ,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    UP,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
    output logic [4*NUM_DIGITS-1:0] COUNT,
    output logic                    TICK,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [W-1:0]          count_q, count_d;
    logic [TW-1:0]         tdiv_q, tdiv_d;
    logic [SW-1:0]         sdiv_q, sdiv_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick, scan_wrap, blank;
    logic [3:0]            nib;

    // Segment pattern {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: seg_lut = 7'h40;
            4'h1: seg_lut = 7'h79;
            4'h2: seg_lut = 7'h24;
            4'h3: seg_lut = 7'h30;
            4'h4: seg_lut = 7'h19;
            4'h5: seg_lut = 7'h12;
            4'h6: seg_lut = 7'h02;
            4'h7: seg_lut = 7'h78;
            4'h8: seg_lut = 7'h00;
            4'h9: seg_lut = 7'h10;
            4'hA: seg_lut = 7'h08;
            4'hB: seg_lut = 7'h03;
            4'hC: seg_lut = 7'h46;
            4'hD: seg_lut = 7'h21;
            4'hE: seg_lut = 7'h06;
            default: seg_lut = 7'h0E;
        endcase
    endfunction

    always_comb begin
        tick      = tdiv_q == TW'(TICK_DIV - 1);
        tdiv_d    = (LOAD || tick) ? '0 : tdiv_q + TW'(1);
        count_d   = LOAD ? LOAD_VAL : (tick && EN) ? (UP ? count_q + W'(1) : count_q - W'(1)) : count_q;
        scan_wrap = sdiv_q == SW'(SCAN_DIV - 1);
        sdiv_d    = scan_wrap ? '0 : sdiv_q + SW'(1);
        idx_d     = !scan_wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        nib       = count_q[4*idx_q +: 4];
        // Digit is blank when it and every more-significant nibble are zero
        blank     = BLANK_LZ && (idx_q != '0) && ((count_q >> (4*idx_q)) == '0);
        an_d      = ~(NUM_DIGITS'(1) << idx_q);
        seg_d     = blank ? 7'h7F : seg_lut(nib);
        dp_d      = !((idx_q == '0) && (tdiv_q < TW'(TICK_DIV / 2)));
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            tdiv_q  <= '0;
            sdiv_q  <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            tdiv_q  <= tdiv_d;
            sdiv_q  <= sdiv_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign COUNT = count_q;
    assign TICK  = tick;
    assign AN    = an_q;
    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
    assign DP    = dp_q;
endmodule

// File: tb/tb_hex_scan_counter.sv
// tb_hex_scan_counter: directed table-driven checks of counting, load, wrap,
// scan/blanking decode and asynchronous reset with 4 digits, TICK_DIV=4, SCAN_DIV=2.
module tb_hex_scan_counter;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [15:0] lv = '0;
    logic [15:0] count;
    logic        tick, ca, cb, cc, cd, ce, cf, cg, dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    int          total = 0, bad = 0;

    typedef struct {
        logic [15:0] lv;
        logic        up;
        int          nt;
        logic [15:0] exp;
    } cvec_t;

    typedef struct {
        logic [15:0] v;
        string       s0, s1, s2, s3;
    } dvec_t;

    cvec_t cv[8];
    dvec_t dv[7];

    hex_scan_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1'b1)) dut (
        .CLK100MHZ(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_VAL(lv),
        .COUNT(count), .TICK(tick), .AN(an),
        .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg), .DP(dp)
    );

    assign seg = {cg, cf, ce, cd, cc, cb, ca};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Active-low pattern from the list of lit segment letters
    function automatic logic [6:0] segs(input string s);
        logic [6:0] r = 7'h7F;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    function automatic string pick(input dvec_t e, input int d);
        return d == 0 ? e.s0 : d == 1 ? e.s1 : d == 2 ? e.s2 : e.s3;
    endfunction

    task automatic setd(input int i, input logic [15:0] v, input string s0, s1, s2, s3);
        dv[i].v = v; dv[i].s0 = s0; dv[i].s1 = s1; dv[i].s2 = s2; dv[i].s3 = s3;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        lv   = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_tick;
        bit ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = tick;
        end
        chk("tick_timeout", ok, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ea;
        logic       edp;
        int         nticks, d, prev;
        int         seen[4];
        bit         ok;
        logic       want[3];
        logic [15:0] wexp[3];

        cv[0] = '{16'hFFFE, 1'b1, 1, 16'hFFFF};
        cv[1] = '{16'hFFFE, 1'b1, 2, 16'h0000};
        cv[2] = '{16'h0001, 1'b0, 1, 16'h0000};
        cv[3] = '{16'h0001, 1'b0, 2, 16'hFFFF};
        cv[4] = '{16'h1234, 1'b1, 3, 16'h1237};
        cv[5] = '{16'h0000, 1'b0, 1, 16'hFFFF};
        cv[6] = '{16'h00FF, 1'b1, 1, 16'h0100};
        cv[7] = '{16'h8000, 1'b0, 1, 16'h7FFF};
        setd(0, 16'h00A3, "abcdg", "abcefg", "", "");
        setd(1, 16'h0000, "abcdef", "", "", "");
        setd(2, 16'h1234, "bcfg", "abcdg", "abdeg", "bc");
        setd(3, 16'hF00E, "adefg", "abcdef", "abcdef", "aefg");
        setd(4, 16'h0B7D, "bcdeg", "abc", "cdefg", "");
        setd(5, 16'h6958, "abcdefg", "acdfg", "abcdfg", "acdefg");
        setd(6, 16'h00C0, "abcdef", "adef", "", "");

        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_tick", tick, 0);

        // Free-run from reset: tick period, count, scan order and heartbeat
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ea  = ~(4'b0001 << (((k - 1) / 2) % 4));
            edp = !((((k - 1) / 2) % 4 == 0) && ((k - 1) % 4 < 2));
            chk("run_tick", tick, (k % 4 == 3));
            chk("run_count", count, k / 4);
            chk("run_an", an, ea);
            chk("run_dp", dp, edp);
        end

        for (int i = 0; i < 8; i++) begin
            up = cv[i].up;
            en = 1'b1;
            do_load(cv[i].lv);
            chk("load_val", count, cv[i].lv);
            for (int n = 0; n < cv[i].nt; n++) wait_tick;
            chk("cnt_vec", count, cv[i].exp);
        end

        // Load coincident with a tick wins and restarts the prescaler
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = tick;
        end
        chk("lt_find_tick", ok, 1);
        up = 1'b1;
        do_load(16'h5A5A);
        chk("lt_count", count, 16'h5A5A);
        chk("lt_tick0", tick, 0);
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("lt_tick", tick, (j == 3));
            chk("lt_hold", count, 16'h5A5A);
        end
        @(negedge clk);
        chk("lt_inc", count, 16'h5A5B);

        en = 1'b0;
        do_load(16'h0042);
        nticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) nticks++;
        end
        chk("en0_ticks", nticks, 5);
        chk("en0_count", count, 16'h0042);

        // UP wiggles every cycle; only its value during TICK counts
        en = 1'b1;
        want = '{1'b1, 1'b1, 1'b0};
        wexp = '{16'h0043, 16'h0044, 16'h0043};
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                @(negedge clk);
                if (tick) begin
                    up = want[i];
                    ok = 1'b1;
                end else up = ~want[i];
            end
            chk("up_timeout", ok, 1);
            @(negedge clk);
            up = ~want[i];
            chk("up_count", count, wexp[i]);
        end

        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_load(dv[i].v);
            @(negedge clk);
            seen = '{0, 0, 0, 0};
            prev = -1;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                d = an == 4'b1110 ? 0 : an == 4'b1101 ? 1 : an == 4'b1011 ? 2 : an == 4'b0111 ? 3 : -1;
                chk("disp_an_onehot", an, d < 0 ? 4'hF ^ 4'h0 : an);
                if (d < 0) begin
                    total++; bad++;
                    $display("FAIL disp_an: got %b want one-hot-low", an);
                end else begin
                    chk("disp_seg", seg, segs(pick(dv[i], d)));
                    if (prev >= 0 && d != prev) chk("disp_order", d, (prev + 1) % 4);
                    seen[d]++;
                    prev = d;
                end
            end
            for (int j = 0; j < 4; j++) chk("disp_dwell", seen[j], 2);
        end

        do_load(16'h1234);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_dp", dp, 1);
        chk("arst_tick", tick, 0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold", count, 0);
        rst = 1'b0; en = 1'b1; up = 1'b1;
        @(negedge clk);
        chk("arst_an0", an, 4'hE);
        repeat (3) @(negedge clk);
        chk("arst_resume", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
